// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB pipeline register: 2-entry skid buffer with registered ready, flush,
// write-back data select, forwarding outputs and a saturating stall counter.
module mem_wb_pipe_reg #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int WB_W    = 2,
    parameter int CNT_W   = 16,
    parameter bit NEGEDGE = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [WB_W-1:0]   wb_i,
    input  logic [DATA_W-1:0] memdata_i,
    input  logic [DATA_W-1:0] aluresult_i,
    input  logic [ADDR_W-1:0] writeaddr_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [WB_W-1:0]   wb_o,
    output logic              regwrite_o,
    output logic [DATA_W-1:0] wbdata_o,
    output logic [ADDR_W-1:0] writeaddr_o,
    output logic              fwd_valid_o,
    output logic [ADDR_W-1:0] fwd_addr_o,
    output logic [DATA_W-1:0] fwd_data_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef struct packed {
        logic [WB_W-1:0]   wb;
        logic [DATA_W-1:0] mem;
        logic [DATA_W-1:0] alu;
        logic [ADDR_W-1:0] addr;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    entry_t             main_q, main_d, skid_q, skid_d, in_ent;
    logic               in_ready_q;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic               clk_act, out_valid, accept, pop;
    logic               ld_main_in, ld_main_skid, ld_skid_in;

    // Falling-edge operation is obtained by inverting the clock once here.
    assign clk_act   = NEGEDGE ? ~clk_i : clk_i;
    assign in_ent    = {wb_i, memdata_i, aluresult_i, writeaddr_i};
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid_i & in_ready_q;
    assign pop       = out_valid & out_ready_i;

    always_ff @(posedge clk_act or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != TWO);
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY:   if (accept) state_d = ONE;
                ONE: begin
                    if (pop && !accept)      state_d = EMPTY;
                    else if (accept && !pop) state_d = TWO;
                end
                TWO:     if (pop) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid_in   = 1'b0;
        if (!flush_i) begin
            case (state_q)
                EMPTY: ld_main_in = accept;
                ONE: begin
                    ld_main_in = accept & pop;
                    ld_skid_in = accept & ~pop;
                end
                TWO:   ld_main_skid = pop;
                default: ;
            endcase
        end
    end

    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (ld_main_in)        main_d = in_ent;
        else if (ld_main_skid) main_d = skid_q;
        if (ld_skid_in)        skid_d = in_ent;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready_i && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_act or negedge rst_i) begin
        if (!rst_i) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid;
    assign wb_o        = main_q.wb;
    assign regwrite_o  = main_q.wb[0] & out_valid;
    assign wbdata_o    = main_q.wb[1] ? main_q.mem : main_q.alu;
    assign writeaddr_o = main_q.addr;
    assign fwd_valid_o = regwrite_o & (main_q.addr != '0);
    assign fwd_addr_o  = main_q.addr;
    assign fwd_data_o  = wbdata_o;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Scoreboard bench for mem_wb_pipe_reg: a falling-edge instance (CNT_W=16) and a
// rising-edge instance (CNT_W=4) share one stimulus stream, each with its own queue.
module tb_mem_wb_pipe_reg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [1:0]  wb_in = '0;
    logic [31:0] mem_in = '0;
    logic [31:0] alu_in = '0;
    logic [4:0]  addr_in = '0;

    logic        a_in_ready, a_out_valid, a_rw, a_fv;
    logic [1:0]  a_wb;
    logic [31:0] a_wbdata, a_fwd_data;
    logic [4:0]  a_waddr, a_fwd_addr;
    logic [15:0] a_stall;

    logic        b_in_ready, b_out_valid, b_rw, b_fv;
    logic [1:0]  b_wb;
    logic [31:0] b_wbdata, b_fwd_data;
    logic [4:0]  b_waddr, b_fwd_addr;
    logic [3:0]  b_stall;

    mem_wb_pipe_reg #(.NEGEDGE(1'b1)) dut_a (
        .clk_i(clk), .rst_i(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(a_in_ready),
        .wb_i(wb_in), .memdata_i(mem_in), .aluresult_i(alu_in), .writeaddr_i(addr_in),
        .out_valid_o(a_out_valid), .out_ready_i(out_ready),
        .wb_o(a_wb), .regwrite_o(a_rw), .wbdata_o(a_wbdata), .writeaddr_o(a_waddr),
        .fwd_valid_o(a_fv), .fwd_addr_o(a_fwd_addr), .fwd_data_o(a_fwd_data),
        .stall_cnt_o(a_stall)
    );

    mem_wb_pipe_reg #(.CNT_W(4), .NEGEDGE(1'b0)) dut_b (
        .clk_i(clk), .rst_i(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(b_in_ready),
        .wb_i(wb_in), .memdata_i(mem_in), .aluresult_i(alu_in), .writeaddr_i(addr_in),
        .out_valid_o(b_out_valid), .out_ready_i(out_ready),
        .wb_o(b_wb), .regwrite_o(b_rw), .wbdata_o(b_wbdata), .writeaddr_o(b_waddr),
        .fwd_valid_o(b_fv), .fwd_addr_o(b_fwd_addr), .fwd_data_o(b_fwd_data),
        .stall_cnt_o(b_stall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  wb;
        logic        rw;
        logic        fv;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Monitor: compare every entry the WB side consumes against the queue head.
    always begin
        exp_t e;
        @(posedge clk);
        #3;
        if (a_out_valid && out_ready) begin
            if (qa.size() == 0) chk("a_unexpected_pop", 64'd1, 64'd0);
            else begin
                e = qa.pop_front();
                chk("a_entry", 64'({a_wb, a_rw, a_fv, a_waddr, a_wbdata}), 64'(e));
                chk("a_fwd", 64'({a_fwd_addr, a_fwd_data}), 64'({e.addr, e.data}));
            end
        end
        if (b_out_valid && out_ready) begin
            if (qb.size() == 0) chk("b_unexpected_pop", 64'd1, 64'd0);
            else begin
                e = qb.pop_front();
                chk("b_entry", 64'({b_wb, b_rw, b_fv, b_waddr, b_wbdata}), 64'(e));
                chk("b_fwd", 64'({b_fwd_addr, b_fwd_data}), 64'({e.addr, e.data}));
            end
        end
    end

    // Inputs change 2 time units after each rising edge, clear of both active edges.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [1:0] wb, input logic [31:0] mem, input logic [31:0] alu,
                        input logic [4:0] addr, input logic [31:0] exp_data,
                        input logic exp_rw, input logic exp_fv, input bit push);
        int n = 0;
        wb_in = wb; mem_in = mem; alu_in = alu; addr_in = addr; in_valid = 1'b1;
        if (push) begin
            qa.push_back({wb, exp_rw, exp_fv, addr, exp_data});
            qb.push_back({wb, exp_rw, exp_fv, addr, exp_data});
        end
        while (!a_in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("send_ready_timeout", 64'd1, 64'd0);
        tick();
    endtask

    task automatic drain(input string name);
        int n = 0;
        in_valid = 1'b0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 30) begin
            tick();
            n++;
        end
        tick();
        chk(name, 64'(qa.size() + qb.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 64'({a_out_valid, b_out_valid}), 64'd0);
        chk({tag, "_in_ready"},  64'({a_in_ready, b_in_ready}),   64'b11);
        chk({tag, "_rw_fwd"},    64'({a_rw, a_fv, b_rw, b_fv}),   64'd0);
        chk({tag, "_wbdata"},    64'({a_wbdata, b_wbdata}),       64'd0);
        chk({tag, "_stall"},     64'({a_stall, b_stall}),         64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        bit ready_ok;
        #1 rst_n = 1'b0;
        tick();
        tick();
        chk_reset_outputs("init_reset");
        rst_n = 1'b1;

        // Streaming, one entry per cycle
        out_ready = 1'b1;
        ready_ok = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            if (!a_in_ready || !b_in_ready) ready_ok = 1'b0;
            send(2'b01, 32'hFFFF_0000, 32'(i), 5'(i), 32'(i), 1'b1, 1'b1, 1'b1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_latency", 64'(qa.size() + qb.size()), 64'd0);
        chk("stream_ready", 64'(ready_ok), 64'd1);

        // Load path and MemtoReg / RegWrite combinations
        send(2'b11, 32'hDEAD_BEEF, 32'h10, 5'd3, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1);
        send(2'b10, 32'hCAFE_F00D, 32'h20, 5'd4, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b1);
        send(2'b00, 32'h55, 32'h77, 5'd9, 32'h77, 1'b0, 1'b0, 1'b1);
        drain("load_drain");

        // Back-pressure: A held, B in skid, C held off for five stall cycles
        do_reset();
        out_ready = 1'b0;
        send(2'b01, 32'h0, 32'hA, 5'd1, 32'hA, 1'b1, 1'b1, 1'b1);
        send(2'b01, 32'h0, 32'hB, 5'd2, 32'hB, 1'b1, 1'b1, 1'b1);
        wb_in = 2'b01; alu_in = 32'hC; addr_in = 5'd3; in_valid = 1'b1;
        qa.push_back({2'b01, 1'b1, 1'b1, 5'd3, 32'hC});
        qb.push_back({2'b01, 1'b1, 1'b1, 5'd3, 32'hC});
        chk("two_in_ready", 64'({a_in_ready, b_in_ready}), 64'd0);
        repeat (4) tick();
        chk("stall_cnt_5", 64'({a_stall, b_stall}), 64'({16'd5, 4'd5}));
        chk("two_still_held", 64'({a_in_ready, b_in_ready}), 64'd0);
        chk("head_held", 64'({a_out_valid, a_wbdata, b_out_valid, b_wbdata}),
            64'({1'b1, 32'hA, 1'b1, 32'hA}));
        out_ready = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        drain("bp_drain");

        // Flush while full with a simultaneous input
        do_reset();
        out_ready = 1'b0;
        send(2'b01, 32'h0, 32'h111, 5'd1, 32'h111, 1'b1, 1'b1, 1'b0);
        send(2'b01, 32'h0, 32'h222, 5'd2, 32'h222, 1'b1, 1'b1, 1'b0);
        wb_in = 2'b01; alu_in = 32'h333; addr_in = 5'd3; in_valid = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", 64'({a_out_valid, b_out_valid}), 64'd0);
        chk("flush_in_ready", 64'({a_in_ready, b_in_ready}), 64'b11);
        chk("flush_keeps_stall", 64'({a_stall, b_stall}), 64'({16'd2, 4'd2}));
        out_ready = 1'b1;
        send(2'b01, 32'h0, 32'h444, 5'd4, 32'h444, 1'b1, 1'b1, 1'b1);
        drain("flush_drain");

        // x0 destination: writes but never forwards
        send(2'b01, 32'h0, 32'h1234, 5'd0, 32'h1234, 1'b1, 1'b0, 1'b1);
        send(2'b01, 32'h0, 32'h99, 5'd5, 32'h99, 1'b1, 1'b1, 1'b1);
        drain("x0_drain");

        // Stall counter saturation on the 4-bit instance
        do_reset();
        out_ready = 1'b0;
        send(2'b01, 32'h0, 32'h5A, 5'd6, 32'h5A, 1'b1, 1'b1, 1'b1);
        in_valid = 1'b0;
        repeat (20) tick();
        chk("stall_cnt_20", 64'(a_stall), 64'd20);
        chk("stall_cnt_sat", 64'(b_stall), 64'hF);
        out_ready = 1'b1;
        drain("sat_drain");

        // Asynchronous reset while full, checked before any clock edge
        out_ready = 1'b0;
        send(2'b11, 32'hAA, 32'hBB, 5'd7, 32'hAA, 1'b1, 1'b1, 1'b0);
        send(2'b11, 32'hCC, 32'hDD, 5'd8, 32'hCC, 1'b1, 1'b1, 1'b0);
        in_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(2'b01, 32'h0, 32'h777, 5'd9, 32'h777, 1'b1, 1'b1, 1'b1);
        drain("post_reset_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
